// File: rtl/shift_pkg.sv
// Shared types and defaults for the shift_stream_pipe streaming shifter.
package shift_pkg;

    typedef enum logic {OP_SHL, OP_ROL} shift_op_e;

    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/param_left_shifter.sv
// Combinational logical left shifter: result = data << amt, zero fill, width 2**N.
module param_left_shifter #(
    parameter int N = 2
) (
    input  logic [(2**N)-1:0] data,
    input  logic [N-1:0]      amt,
    output logic [(2**N)-1:0] result
);

    assign result = data << amt;

endmodule

// File: rtl/shift_result_fifo.sv
// Small result FIFO with registered full flag; memory is cleared by reset.
module shift_result_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic          push_en, pop_en;

    // full is a registered flag, so a pop while full never frees a slot for a same-cycle push
    assign push_en = push && !full;
    assign pop_en  = pop && (count != '0);
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push_en, pop_en})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push_en) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_next;
            full  <= (count_next == DEPTH_C);
        end
    end

endmodule

// File: rtl/shift_stream_pipe.sv
// Streaming valid/ready wrapper around param_left_shifter with an output FIFO.
// Optional rotate-left mode is enabled by defining SHIFT_ROTATE_EN.
module shift_stream_pipe
    import shift_pkg::*;
#(
    parameter int N     = 2,
    parameter int DEPTH = 2,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [(2**N)-1:0]    in_data,
    input  logic [N-1:0]         in_amt,
`ifdef SHIFT_ROTATE_EN
    input  logic                 in_rot,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [(2**N)-1:0]    out_data,
    output logic [CNT_W-1:0]     op_count
);

    localparam int W = 2**N;

    logic         s1_valid;
    logic [W-1:0] s1_data;
    logic [N-1:0] s1_amt;
    logic         fifo_full, fifo_empty;
    logic         accept, push, pop;
    logic [W-1:0] shl_y, result;

    assign in_ready  = !s1_valid || !fifo_full;
    assign accept    = in_valid && in_ready;
    assign push      = s1_valid && !fifo_full;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_amt   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_data  <= in_data;
            s1_amt   <= in_amt;
        end else if (push) begin
            s1_valid <= 1'b0;
        end
    end

    param_left_shifter #(.N(N)) u_shl (
        .data   (s1_data),
        .amt    (s1_amt),
        .result (shl_y)
    );

`ifdef SHIFT_ROTATE_EN
    shift_op_e      s1_op;
    logic [2*W-1:0] rot_wide;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_op <= OP_SHL;
        end else if (accept) begin
            s1_op <= in_rot ? OP_ROL : OP_SHL;
        end
    end

    // Upper half of the doubled word shifted left is the rotate; amt=0 yields data unchanged.
    assign rot_wide = {s1_data, s1_data} << s1_amt;
    assign result   = (s1_op == OP_ROL) ? rot_wide[2*W-1:W] : shl_y;
`else
    assign result = shl_y;
`endif

    shift_result_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (result),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_count <= '0;
        end else if (pop) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule
